// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - state encoding and WM8731 register table for the codec config sequencer
package codec_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_PWR,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_READY,
    ST_UPD_ISSUE,
    ST_UPD_WAIT,
    ST_ERROR
  } cfg_state_t;

  localparam int CFG_NUM_REGS = 10;

  localparam logic [7:0] WM8731_DEV_ADDR = 8'h34;

  // R15 reset goes first and R9 (active) goes last so the codec is only enabled once fully set up.
  localparam logic [15:0] CFG_TABLE [0:CFG_NUM_REGS-1] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
    16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1201
  };

endpackage

// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - walks the codec register table over I2C, then arbitrates runtime register writes
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_REGS     = CFG_NUM_REGS,
  parameter int         STARTUP_WAIT = 2000,
  parameter int         GAP_CYCLES   = 40,
  parameter int         MAX_RETRIES  = 3,
  parameter bit         AUTO_START   = 1'b1,
  parameter logic [7:0] DEV_ADDR     = WM8731_DEV_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_upd_valid,
  input  logic [15:0] i_upd_word,
  output logic        o_upd_ready,
  output logic        o_i2c_valid,
  output logic [23:0] o_i2c_data,
  input  logic        i_i2c_ready,
  input  logic        i_i2c_done,
  input  logic        i_i2c_nack,
  output logic        o_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  output logic [3:0]  o_cur_index
);

  localparam int CNT_MAX = (STARTUP_WAIT > GAP_CYCLES) ? STARTUP_WAIT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] PWR_LAST  = CW'((STARTUP_WAIT > 0) ? STARTUP_WAIT - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REGS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  cfg_state_t    r_state;
  cfg_state_t    r_gap_next;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_index;
  logic [RW-1:0] r_retry;
  logic [15:0]   r_upd_word;
  logic          r_i2c_valid;
  logic [23:0]   r_i2c_data;
  logic          r_busy;
  logic          r_cfg_done;
  logic          r_cfg_err;

  assign o_i2c_valid = r_i2c_valid;
  assign o_i2c_data  = r_i2c_data;
  assign o_busy      = r_busy;
  assign o_cfg_done  = r_cfg_done;
  assign o_cfg_err   = r_cfg_err;
  assign o_cur_index = 4'(r_index);
  assign o_upd_ready = (r_state == ST_READY) && i_upd_valid && !i_start;

  task automatic begin_sequence();
    r_state    <= ST_WAIT_PWR;
    r_cnt      <= '0;
    r_index    <= '0;
    r_retry    <= '0;
    r_cfg_done <= 1'b0;
    r_cfg_err  <= 1'b0;
    r_busy     <= 1'b1;
  endtask

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_gap_next  <= ST_ISSUE;
      r_cnt       <= '0;
      r_index     <= '0;
      r_retry     <= '0;
      r_upd_word  <= '0;
      r_i2c_valid <= 1'b0;
      r_i2c_data  <= '0;
      r_busy      <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start || AUTO_START) begin_sequence();
        end
        ST_WAIT_PWR: begin
          if (r_cnt >= PWR_LAST) begin
            r_cnt       <= '0;
            r_state     <= ST_ISSUE;
            r_i2c_valid <= 1'b1;
            r_i2c_data  <= {DEV_ADDR, CFG_TABLE[r_index]};
          end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (i_i2c_ready) begin
            r_i2c_valid <= 1'b0;
            r_state     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (i_i2c_done) begin
            r_cnt <= '0;
            if (i_i2c_nack) begin
              if (r_retry >= RETRY_MAX) begin
                r_state   <= ST_ERROR;
                r_cfg_err <= 1'b1;
                r_busy    <= 1'b0;
              end else begin
                r_retry    <= r_retry + 1'b1;
                r_state    <= ST_GAP;
                r_gap_next <= ST_ISSUE;
              end
            end else begin
              r_retry <= '0;
              r_state <= ST_GAP;
              if (r_index == IDX_LAST) begin
                r_gap_next <= ST_READY;
              end else begin
                r_index    <= r_index + 1'b1;
                r_gap_next <= ST_ISSUE;
              end
            end
          end
        end
        ST_GAP: begin
          if (r_cnt >= GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= r_gap_next;
            if (r_gap_next == ST_ISSUE) begin
              r_i2c_valid <= 1'b1;
              r_i2c_data  <= {DEV_ADDR, CFG_TABLE[r_index]};
            end else if (r_gap_next == ST_UPD_ISSUE) begin
              r_i2c_valid <= 1'b1;
              r_i2c_data  <= {DEV_ADDR, r_upd_word};
            end else begin
              r_cfg_done <= 1'b1;
              r_busy     <= 1'b0;
            end
          end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (i_start) begin
            begin_sequence();
          end else if (i_upd_valid) begin
            r_upd_word  <= i_upd_word;
            r_state     <= ST_UPD_ISSUE;
            r_i2c_valid <= 1'b1;
            r_i2c_data  <= {DEV_ADDR, i_upd_word};
            r_retry     <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_UPD_ISSUE: begin
          if (i_i2c_ready) begin
            r_i2c_valid <= 1'b0;
            r_state     <= ST_UPD_WAIT;
          end
        end
        ST_UPD_WAIT: begin
          if (i_i2c_done) begin
            r_cnt <= '0;
            if (i_i2c_nack) begin
              if (r_retry >= RETRY_MAX) begin
                r_state    <= ST_ERROR;
                r_cfg_err  <= 1'b1;
                r_cfg_done <= 1'b0;
                r_busy     <= 1'b0;
              end else begin
                r_retry    <= r_retry + 1'b1;
                r_state    <= ST_GAP;
                r_gap_next <= ST_UPD_ISSUE;
              end
            end else begin
              r_retry    <= '0;
              r_state    <= ST_GAP;
              r_gap_next <= ST_READY;
            end
          end
        end
        ST_ERROR: begin
          if (i_start) begin_sequence();
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb/tb_codec_cfg_seq.sv - scoreboard bench with an I2C responder model, random NACKs and random runtime writes
module tb_codec_cfg_seq;

  localparam int SW   = 4;
  localparam int GAP  = 2;
  localparam int MAXR = 2;
  localparam int NREG = 10;
  localparam logic [15:0] TBL [0:NREG-1] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
    16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1201
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_word = '0;
  logic        upd_ready;
  logic        i2c_valid;
  logic [23:0] i2c_data;
  logic        i2c_ready = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [3:0]  cur_index;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [23:0] exp_q[$];
  int          nack_plan[NREG];
  int          nack_left[NREG];
  int          upd_nack_left = 0;
  bit          upd_mode = 1'b0;
  int          resp_phase = 0;
  bit          chk_spacing = 1'b0;
  bit          start_pending = 1'b0;
  int          start_cyc = 0;

  codec_cfg_seq #(
    .NUM_REGS    (NREG),
    .STARTUP_WAIT(SW),
    .GAP_CYCLES  (GAP),
    .MAX_RETRIES (MAXR),
    .AUTO_START  (1'b1),
    .DEV_ADDR    (8'h34)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_upd_valid(upd_valid),
    .i_upd_word (upd_word),
    .o_upd_ready(upd_ready),
    .o_i2c_valid(i2c_valid),
    .o_i2c_data (i2c_data),
    .i_i2c_ready(i2c_ready),
    .i_i2c_done (i2c_done),
    .i_i2c_nack (i2c_nack),
    .o_busy     (busy),
    .o_cfg_done (cfg_done),
    .o_cfg_err  (cfg_err),
    .o_cur_index(cur_index)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // I2C master stand-in: ready one cycle after valid, done five cycles after acceptance.
  initial begin : responder
    logic [15:0] w;
    int          cnt;
    bit          nk;
    w = '0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (rst) begin
        i2c_ready  = 1'b0;
        resp_phase = 0;
        continue;
      end
      case (resp_phase)
        0: if (i2c_valid) resp_phase = 1;
        1: begin
          i2c_ready  = 1'b1;
          w          = i2c_data[15:0];
          resp_phase = 2;
        end
        2: begin
          i2c_ready  = 1'b0;
          cnt        = 0;
          resp_phase = 3;
        end
        3: begin
          cnt++;
          if (cnt == 4) begin
            nk = 1'b0;
            if (upd_mode) begin
              if (upd_nack_left > 0) begin
                nk = 1'b1;
                upd_nack_left--;
              end
            end else begin
              for (int i = 0; i < NREG; i++)
                if (TBL[i] == w && nack_left[i] > 0) begin
                  nk = 1'b1;
                  nack_left[i]--;
                end
            end
            i2c_done   = 1'b1;
            i2c_nack   = nk;
            resp_phase = 0;
          end
        end
        default: resp_phase = 0;
      endcase
    end
  end

  initial begin : monitor
    logic        prev_v;
    bit          have_done;
    int          done_cyc;
    logic [23:0] e;
    prev_v    = 1'b0;
    have_done = 1'b0;
    done_cyc  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v    = 1'b0;
        have_done = 1'b0;
        continue;
      end
      if (i2c_valid && !prev_v) begin
        if (start_pending) begin
          chk("start_to_valid", 32'(cyc - start_cyc), 32'(SW + 1));
          start_pending = 1'b0;
        end else if (chk_spacing && have_done) begin
          chk("done_to_valid", 32'(cyc - done_cyc), 32'(GAP + 1));
        end
        have_done = 1'b0;
      end
      if (i2c_done) begin
        have_done = 1'b1;
        done_cyc  = cyc;
      end
      if (i2c_valid && i2c_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: actual=0x%06h expected=none", i2c_data);
        end else begin
          e = exp_q.pop_front();
          chk("i2c_data", 32'(i2c_data), 32'(e));
        end
      end
      prev_v = i2c_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each word is attempted once plus once per NACK, and a word NACKed more than MAXR times ends the run.
  task automatic push_run(output bit err, output int eidx);
    int att;
    err  = 1'b0;
    eidx = NREG - 1;
    upd_mode = 1'b0;
    for (int i = 0; i < NREG; i++) nack_left[i] = nack_plan[i];
    for (int i = 0; i < NREG && !err; i++) begin
      att = (nack_plan[i] > MAXR) ? MAXR + 1 : nack_plan[i] + 1;
      repeat (att) exp_q.push_back({8'h34, TBL[i]});
      if (nack_plan[i] > MAXR) begin
        err  = 1'b1;
        eidx = i;
      end
    end
  endtask

  task automatic do_start();
    start         = 1'b1;
    start_cyc     = cyc;
    start_pending = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_settle(input string name);
    int n;
    n = 0;
    while (!((cfg_done || cfg_err) && !busy && exp_q.size() == 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual=busy expected=settled", name);
    end
  endtask

  task automatic finish_run(input string name, input bit err, input int eidx);
    wait_settle(name);
    chk({name, "_cfg_done"}, 32'(cfg_done), 32'(!err));
    chk({name, "_cfg_err"}, 32'(cfg_err), 32'(err));
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_cur_index"}, 32'(cur_index), 32'(eidx));
    chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
    if (err) chk({name, "_err_valid"}, 32'(i2c_valid), 32'd0);
  endtask

  task automatic run_seq(input string name);
    bit err;
    int eidx;
    push_run(err, eidx);
    do_start();
    finish_run(name, err, eidx);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
  endtask

  task automatic run_upd(input string name, input logic [15:0] w, input int nacks);
    bit err;
    int att;
    err = (nacks > MAXR);
    att = err ? MAXR + 1 : nacks + 1;
    upd_mode      = 1'b1;
    upd_nack_left = nacks;
    repeat (att) exp_q.push_back({8'h34, w});
    upd_word  = w;
    upd_valid = 1'b1;
    @(negedge clk);
    chk({name, "_upd_ready"}, 32'(upd_ready), 32'd1);
    @(negedge clk);
    chk({name, "_upd_ready_once"}, 32'(upd_ready), 32'd0);
    tick();
    upd_valid = 1'b0;
    finish_run(name, err, NREG - 1);
    upd_mode = 1'b0;
  endtask

  initial begin : stim
    bit          err;
    int          eidx;
    int          n;
    logic [15:0] rw;
    int          rn;

    clear_plan();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_i2c_valid", 32'(i2c_valid), 32'd0);
    chk("rst_i2c_data", 32'(i2c_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_cur_index", 32'(cur_index), 32'd0);

    push_run(err, eidx);
    chk_spacing = 1'b1;
    tick();
    rst = 1'b0;
    finish_run("autostart", err, eidx);

    run_seq("restart");
    chk_spacing = 1'b0;

    clear_plan();
    nack_plan[5] = 1;
    run_seq("nack5_once");

    clear_plan();
    nack_plan[2] = 3;
    run_seq("nack2_exhaust");
    clear_plan();
    run_seq("after_error");

    push_run(err, eidx);
    upd_word  = 16'h0815;
    upd_valid = 1'b1;
    start     = 1'b1;
    start_cyc = cyc;
    start_pending = 1'b1;
    @(negedge clk);
    chk("start_vs_upd_ready", 32'(upd_ready), 32'd0);
    tick();
    start     = 1'b0;
    upd_valid = 1'b0;
    finish_run("start_vs_upd", err, eidx);

    run_upd("upd_0479", 16'h0479, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++)
        nack_plan[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_seq("rand_seq");
    end
    clear_plan();
    if (cfg_err) run_seq("rand_seq_recover");

    for (int r = 0; r < 6; r++) begin
      rw = 16'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_upd("rand_upd", rw, rn);
      if (cfg_err) run_seq("rand_upd_recover");
    end

    clear_plan();
    push_run(err, eidx);
    do_start();
    n = 0;
    while (!(resp_phase == 3 && cur_index == 4'd4) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL rst_mid_wait: actual=not_reached expected=wait_done_index4");
    end
    rst = 1'b1;
    exp_q.delete();
    start_pending = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_i2c_valid", 32'(i2c_valid), 32'd0);
    chk("midrst_i2c_data", 32'(i2c_data), 32'd0);
    chk("midrst_upd_ready", 32'(upd_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cfg_done", 32'(cfg_done), 32'd0);
    chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
    chk("midrst_cur_index", 32'(cur_index), 32'd0);
    push_run(err, eidx);
    tick();
    rst = 1'b0;
    finish_run("after_midrst", err, eidx);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/codec_cfg_seq.md
# codec_cfg_seq

Register-write sequencer and arbiter for the WM8731 codec control port. After reset, or on request, it walks a fixed table of codec register words and issues each one as a write transaction to a byte-level I2C master, retrying on NACK. Once configuration completes, it grants the same I2C master to single runtime register writes, such as mic-boost or volume changes from the level/SNR control logic. It sits between the I2C master and the audio front-end controllers, in the i2c_clk domain.

## Interface
- NUM_REGS, 10: number of entries in the configuration table.
- STARTUP_WAIT, 2000: cycles idle after start before the first write (codec power-up settle).
- GAP_CYCLES, 40: idle cycles between consecutive transactions.
- MAX_RETRIES, 3: NACK retries per word before declaring an error.
- AUTO_START, 1: if 1, the sequence starts automatically on the first cycle after reset.
- DEV_ADDR, 8'h34: codec write address byte.

- clk  in  1  sequencer clock, the i2c_clk domain. One clock only; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that (re)runs the full table. Ignored while busy.
- upd_valid  in  1  runtime write request.
- upd_word  in  16  {reg[6:0], data[8:0]}. Must stay stable while upd_valid is high.
- upd_ready  out  1  runtime write accepted this cycle (upd_valid & upd_ready).
- i2c_valid  out  1  transaction request to the I2C master.
- i2c_data  out  24  {DEV_ADDR, word[15:0]}.
- i2c_ready  in  1  master accepts the request when i2c_valid & i2c_ready.
- i2c_done  in  1  one-cycle pulse at the end of a transaction.
- i2c_nack  in  1  qualified by i2c_done; 1 means the slave did not acknowledge.
- busy  out  1  sequence or runtime write in progress.
- cfg_done  out  1  table written successfully. Sticky until the next start or rst.
- cfg_err  out  1  retry limit exceeded. Sticky until the next start or rst.
- cur_index  out  4  table index being written, for debug and LEDs.

## Operation
- States: IDLE, WAIT_PWR, ISSUE, WAIT_DONE, GAP, READY, UPD_ISSUE, UPD_WAIT, ERROR.
- IDLE → WAIT_PWR on start, or unconditionally on the first cycle after rst when AUTO_START=1. This transition clears index, retry count, cfg_done and cfg_err.
- WAIT_PWR: count STARTUP_WAIT cycles, then go to ISSUE.
- ISSUE: drive i2c_valid=1 with i2c_data={DEV_ADDR, table[index]}. Hold both until i2c_ready=1, then go to WAIT_DONE.
- WAIT_DONE: wait for i2c_done.
  - If i2c_nack=1 and retry count < MAX_RETRIES: increment the retry count and go to GAP, then reissue the same index.
  - If i2c_nack=1 and retry count = MAX_RETRIES: go to ERROR.
  - On ACK: reset the retry count and go to GAP. If index = NUM_REGS-1, GAP is followed by READY instead of ISSUE. Otherwise increment index.
- READY: cfg_done=1 and upd_ready=upd_valid & ~start.
  - start has priority and goes to WAIT_PWR.
  - An accepted runtime write latches upd_word and goes to UPD_ISSUE → UPD_WAIT, using the same handshake and retry rules. It returns to READY after GAP. Runtime-write retry exhaustion goes to ERROR and clears cfg_done.
- ERROR: cfg_err=1 and i2c_valid=0. Only start or rst leaves this state.
- Table, with word = {reg, data}: 0x1E00 (R15 reset), 0x0017, 0x0217, 0x0479, 0x0679, 0x0815 (mic in, boost), 0x0A00, 0x0C00, 0x0E42 (I2S master), 0x1201 (R9 active, written last).
- Arithmetic: counters are sized with $clog2 of their limit. Counters saturate at their limit and never wrap. cur_index = index zero-extended to 4 bits.

## Timing
- Reset values: i2c_valid=0, i2c_data=0, upd_ready=0, busy=0, cfg_done=0, cfg_err=0, cur_index=0, state=IDLE.
- All outputs are registered except upd_ready, which is combinational from state, upd_valid and start.
- start on cycle N: busy=1 from N+1. The first i2c_valid rises at N+1+STARTUP_WAIT.
- From the i2c_done of index k, i2c_valid for index k+1 rises GAP_CYCLES+1 cycles later.
- i2c_done arriving while not in WAIT_DONE or UPD_WAIT is ignored.
- If i2c_done and start arrive together mid-sequence, start is ignored and i2c_done is processed.
- rst mid-transaction drops i2c_valid the next cycle. The I2C master must be reset by the same rst.

## Structure
- Package codec_cfg_pkg: the state enum, CFG_NUM_REGS, the CFG_TABLE constant array of 16-bit words, and the WM8731_DEV_ADDR constant.
- No sub-module is required. One shared cycle counter serves WAIT_PWR and GAP.

## Test plan
Bench parameters: STARTUP_WAIT=4, GAP_CYCLES=2, MAX_RETRIES=2. A bench I2C model responds with ready after 1 cycle and done after 5 cycles.
- Reset release with AUTO_START=1: exactly 10 transactions occur. i2c_data sequence is 0x341E00 … 0x341201, then cfg_done=1 and busy=0.
- Timing check: the first i2c_valid rises exactly 5 cycles after start. Spacing from done to the next valid is exactly 3 cycles.
- NACK once on index 5: index 5 is reissued once, the sequence completes, and cfg_err=0.
- NACK 3 times on index 2: 3 attempts occur, then ERROR with cfg_err=1, cfg_done=0, cur_index=2. A later start reruns the sequence from index 0.
- In READY, upd_valid with upd_word=0x0815 and start asserted together: upd_ready=0 and the sequence restarts.
- In READY, upd_valid with 0x0479 alone: upd_ready for 1 cycle, one transaction of 0x340479, cfg_done stays 1.
- rst asserted during WAIT_DONE of index 4: all outputs return to their reset values the next cycle, and with AUTO_START=1 the sequence restarts from index 0.
